// File: rtl/fsm_params.sv
// rtl/fsm_params.sv - shared state codes, threshold limits and error_src bit order for fsm_controller
package fsm_params;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_e;

    localparam logic [3:0] UMBRAL_MIN         = 4'd1;
    localparam logic [3:0] UMBRAL_MAX_DEFAULT = 4'd7;

    localparam int SRC_VC0 = 0;
    localparam int SRC_VC1 = 1;
    localparam int SRC_D0  = 2;
    localparam int SRC_D1  = 3;

    function automatic logic [3:0] pack_flags(input logic d1, input logic d0,
                                              input logic vc1, input logic vc0);
        logic [3:0] v;
        v          = '0;
        v[SRC_D1]  = d1;
        v[SRC_D0]  = d0;
        v[SRC_VC1] = vc1;
        v[SRC_VC0] = vc0;
        return v;
    endfunction

endpackage

// File: rtl/umbral_clamp.sv
// rtl/umbral_clamp.sv - combinational 4-bit FIFO threshold clamp into [UMBRAL_MIN, MAX]
module umbral_clamp
    import fsm_params::*;
#(
    parameter logic [3:0] MAX = UMBRAL_MAX_DEFAULT
) (
    input  logic [3:0] raw_i,
    output logic [3:0] clamped_o
);

    always_comb begin
        clamped_o = raw_i;
        if (raw_i == 4'd0) begin
            clamped_o = UMBRAL_MIN;
        end else if (raw_i > MAX) begin
            clamped_o = MAX;
        end
    end

endmodule

// File: rtl/fsm_controller.sv
// rtl/fsm_controller.sv - FIFO threshold/state controller FSM; IDLE_FILTER_EN adds the ACTIVE->IDLE debounce
module fsm_controller
    import fsm_params::*;
#(
    parameter logic [3:0] UMBRAL_MAX  = UMBRAL_MAX_DEFAULT,
    parameter int         IDLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_L,
    input  logic       init,
    input  logic [3:0] Umbral_VC0,
    input  logic [3:0] Umbral_VC1,
    input  logic [3:0] Umbral_D0,
    input  logic [3:0] Umbral_D1,
    input  logic       empty_fifo_VC0,
    input  logic       empty_fifo_VC1,
    input  logic       empty_fifo_D0,
    input  logic       empty_fifo_D1,
    input  logic       error_VC0,
    input  logic       error_VC1,
    input  logic       error_D0,
    input  logic       error_D1,
    output logic [2:0] state,
    output logic       idle_out,
    output logic       active_out,
    output logic       error_out,
    output logic [3:0] error_src,
    output logic [3:0] Umbral_VC0_out,
    output logic [3:0] Umbral_VC1_out,
    output logic [3:0] Umbral_D0_out,
    output logic [3:0] Umbral_D1_out
);

    if (IDLE_CYCLES < 1) begin : g_bad_idle_cycles
        $error("IDLE_CYCLES must be at least 1");
    end

    state_e          state_q, state_d;
    logic            idle_q, active_q, error_q;
    logic [3:0]      err_src_q, err_src_d;
    logic [3:0][3:0] umb_raw, umb_clamped, umb_q, umb_d;
    logic [3:0]      err_vec;
    logic            all_empty;

    assign err_vec   = pack_flags(error_D1, error_D0, error_VC1, error_VC0);
    assign all_empty = empty_fifo_VC0 & empty_fifo_VC1 & empty_fifo_D0 & empty_fifo_D1;

    assign umb_raw[SRC_VC0] = Umbral_VC0;
    assign umb_raw[SRC_VC1] = Umbral_VC1;
    assign umb_raw[SRC_D0]  = Umbral_D0;
    assign umb_raw[SRC_D1]  = Umbral_D1;

    for (genvar g = 0; g < 4; g++) begin : g_clamp
        umbral_clamp #(.MAX(UMBRAL_MAX)) u_clamp (
            .raw_i     (umb_raw[g]),
            .clamped_o (umb_clamped[g])
        );
    end

`ifdef IDLE_FILTER_EN
    localparam int               CNT_W    = $clog2(IDLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    always_comb begin
        state_d   = state_q;
        err_src_d = err_src_q;
        umb_d     = umb_q;
`ifdef IDLE_FILTER_EN
        cnt_d     = '0;
`endif
        if (state_q == ST_INIT) begin
            umb_d = umb_clamped;
        end
        case (state_q)
            ST_ERROR: state_d = ST_ERROR;
            ST_RESET, ST_INIT, ST_IDLE, ST_ACTIVE: begin
                if (|err_vec) begin
                    state_d   = ST_ERROR;
                    err_src_d = err_vec;
                end else if (init) begin
                    state_d = ST_INIT;
                end else begin
                    case (state_q)
                        ST_RESET: state_d = ST_INIT;
                        ST_INIT:  state_d = ST_IDLE;
                        ST_IDLE:  if (!all_empty) state_d = ST_ACTIVE;
                        ST_ACTIVE: begin
`ifdef IDLE_FILTER_EN
                            // cnt_q counts all-empty cycles already seen; this one completes the run
                            if (all_empty) begin
                                if (cnt_q >= CNT_LAST) state_d = ST_IDLE;
                                else                   cnt_d   = cnt_q + CNT_W'(1);
                            end
`else
                            if (all_empty) state_d = ST_IDLE;
`endif
                        end
                        default: state_d = state_q;
                    endcase
                end
            end
            default: state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q   <= ST_RESET;
            idle_q    <= 1'b0;
            active_q  <= 1'b0;
            error_q   <= 1'b0;
            err_src_q <= '0;
            umb_q     <= {4{UMBRAL_MIN}};
`ifdef IDLE_FILTER_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idle_q    <= (state_d == ST_IDLE);
            active_q  <= (state_d == ST_ACTIVE);
            error_q   <= (state_d == ST_ERROR);
            err_src_q <= err_src_d;
            umb_q     <= umb_d;
`ifdef IDLE_FILTER_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign state          = state_q;
    assign idle_out       = idle_q;
    assign active_out     = active_q;
    assign error_out      = error_q;
    assign error_src      = err_src_q;
    assign Umbral_VC0_out = umb_q[SRC_VC0];
    assign Umbral_VC1_out = umb_q[SRC_VC1];
    assign Umbral_D0_out  = umb_q[SRC_D0];
    assign Umbral_D1_out  = umb_q[SRC_D1];

endmodule

// File: tb/tb_fsm_controller.sv
// tb/tb_fsm_controller.sv - directed plus randomized bench for fsm_controller against a behavioural model
module tb_fsm_controller;

`ifdef IDLE_FILTER_EN
    localparam int NEED = 4;
`else
    localparam int NEED = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_L = 1'b0;
    logic       init = 1'b0;
    logic [3:0] Umbral_VC0 = 4'd5, Umbral_VC1 = 4'd2, Umbral_D0 = 4'd3, Umbral_D1 = 4'd7;
    logic       empty_fifo_VC0 = 1'b1, empty_fifo_VC1 = 1'b1, empty_fifo_D0 = 1'b1, empty_fifo_D1 = 1'b1;
    logic       error_VC0 = 1'b0, error_VC1 = 1'b0, error_D0 = 1'b0, error_D1 = 1'b0;
    logic [2:0] state;
    logic       idle_out, active_out, error_out;
    logic [3:0] error_src;
    logic [3:0] Umbral_VC0_out, Umbral_VC1_out, Umbral_D0_out, Umbral_D1_out;

    fsm_controller dut (
        .clk(clk), .reset_L(reset_L), .init(init),
        .Umbral_VC0(Umbral_VC0), .Umbral_VC1(Umbral_VC1), .Umbral_D0(Umbral_D0), .Umbral_D1(Umbral_D1),
        .empty_fifo_VC0(empty_fifo_VC0), .empty_fifo_VC1(empty_fifo_VC1),
        .empty_fifo_D0(empty_fifo_D0), .empty_fifo_D1(empty_fifo_D1),
        .error_VC0(error_VC0), .error_VC1(error_VC1), .error_D0(error_D0), .error_D1(error_D1),
        .state(state), .idle_out(idle_out), .active_out(active_out), .error_out(error_out),
        .error_src(error_src),
        .Umbral_VC0_out(Umbral_VC0_out), .Umbral_VC1_out(Umbral_VC1_out),
        .Umbral_D0_out(Umbral_D0_out), .Umbral_D1_out(Umbral_D1_out)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Model: state as its numeric code, run = consecutive all-empty cycles seen while ACTIVE
    int         m_state;
    logic [3:0] m_src;
    logic [3:0] m_thr [4];
    int         m_run;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] clampv(input logic [3:0] v);
        if (v == 4'd0) return 4'd1;
        if (v > 4'd7)  return 4'd7;
        return v;
    endfunction

    task automatic mdl_reset();
        m_state = 0;
        m_src   = 4'b0;
        for (int i = 0; i < 4; i++) m_thr[i] = 4'd1;
        m_run   = 0;
    endtask

    task automatic mdl_step();
        logic [3:0] errs;
        logic       all_e;
        errs  = {error_D1, error_D0, error_VC1, error_VC0};
        all_e = empty_fifo_VC0 && empty_fifo_VC1 && empty_fifo_D0 && empty_fifo_D1;
        if (m_state == 1) begin
            m_thr[0] = clampv(Umbral_VC0);
            m_thr[1] = clampv(Umbral_VC1);
            m_thr[2] = clampv(Umbral_D0);
            m_thr[3] = clampv(Umbral_D1);
        end
        if (m_state == 4) begin
            m_state = 4;
        end else if (errs != 4'b0) begin
            m_state = 4;
            m_src   = errs;
        end else if (init) begin
            m_state = 1;
        end else if (m_state == 0) begin
            m_state = 1;
        end else if (m_state == 1) begin
            m_state = 2;
        end else if (m_state == 2) begin
            if (!all_e) m_state = 3;
        end else begin
            m_run = all_e ? m_run + 1 : 0;
            if (m_run >= NEED) m_state = 2;
        end
        if (m_state != 3) m_run = 0;
    endtask

    task automatic check_all();
        expect_eq("state", state, m_state);
        expect_eq("idle_out", idle_out, m_state == 2);
        expect_eq("active_out", active_out, m_state == 3);
        expect_eq("error_out", error_out, m_state == 4);
        expect_eq("error_src", error_src, m_src);
        expect_eq("Umbral_VC0_out", Umbral_VC0_out, m_thr[0]);
        expect_eq("Umbral_VC1_out", Umbral_VC1_out, m_thr[1]);
        expect_eq("Umbral_D0_out", Umbral_D0_out, m_thr[2]);
        expect_eq("Umbral_D1_out", Umbral_D1_out, m_thr[3]);
    endtask

    task automatic cycle();
        @(posedge clk);
        if (reset_L) mdl_step();
        @(negedge clk);
        check_all();
    endtask

    // Called just after a falling edge: reset lands between clock edges
    task automatic async_reset();
        #2;
        reset_L = 1'b0;
        mdl_reset();
        #1;
        check_all();
        @(posedge clk);
        @(negedge clk);
        check_all();
        reset_L = 1'b1;
    endtask

    task automatic set_empty(input logic [3:0] e);
        {empty_fifo_D1, empty_fifo_D0, empty_fifo_VC1, empty_fifo_VC0} = e;
    endtask

    initial begin
        int k;
        mdl_reset();
        init = 1'b1;
        cycle();
        cycle();
        expect_eq("reset_state", state, 3'd0);

        // Release with init high for three cycles, then IDLE
        reset_L = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        expect_eq("init_x3_state", state, 3'd1);
        init = 1'b0;
        cycle();
        expect_eq("after_init_idle", state, 3'd2);
        expect_eq("D0_captured", Umbral_D0_out, 4'd3);

        // Clamp boundaries
        init = 1'b1; Umbral_D1 = 4'd0; Umbral_VC0 = 4'd12;
        cycle();
        cycle();
        init = 1'b0;
        cycle();
        expect_eq("clamp_D1_zero", Umbral_D1_out, 4'd1);
        expect_eq("clamp_VC0_high", Umbral_VC0_out, 4'd7);

        // IDLE -> ACTIVE -> IDLE latency
        empty_fifo_VC1 = 1'b0;
        cycle();
        expect_eq("enter_active", state, 3'd3);
        empty_fifo_VC1 = 1'b1;
        k = 0;
        while (state != 3'd2 && k < 10) begin
            cycle();
            k++;
        end
        expect_eq("idle_latency", k, NEED);

        // Error together with init from ACTIVE
        empty_fifo_VC0 = 1'b0;
        cycle();
        error_D1 = 1'b1; init = 1'b1;
        cycle();
        expect_eq("err_state", state, 3'd4);
        expect_eq("err_src_d1", error_src, 4'b1000);
        error_D1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            init = ~init;
            cycle();
        end
        expect_eq("err_absorbing", state, 3'd4);
        init = 1'b0; empty_fifo_VC0 = 1'b1;

        // Async reset in the middle of ACTIVE
        async_reset();
        cycle();
        cycle();
        empty_fifo_D0 = 1'b0;
        cycle();
        expect_eq("active_before_rst", state, 3'd3);
        async_reset();
        expect_eq("rst_thr_D1", Umbral_D1_out, 4'd1);
        expect_eq("rst_state", state, 3'd0);

        // init from ACTIVE with every FIFO non-empty
        cycle();
        cycle();
        cycle();
        set_empty(4'b0000);
        cycle();
        expect_eq("active_again", state, 3'd3);
        init = 1'b1; Umbral_VC1 = 4'd6; Umbral_D0 = 4'd9;
        cycle();
        expect_eq("active_to_init", state, 3'd1);
        cycle();
        init = 1'b0;
        cycle();
        expect_eq("recap_VC1", Umbral_VC1_out, 4'd6);
        expect_eq("recap_D0", Umbral_D0_out, 4'd7);

        for (int i = 0; i < 1500; i++) begin
            init = ($urandom_range(0, 15) == 0);
            Umbral_VC0 = 4'($urandom); Umbral_VC1 = 4'($urandom);
            Umbral_D0  = 4'($urandom); Umbral_D1  = 4'($urandom);
            set_empty({($urandom_range(0, 5) != 0), ($urandom_range(0, 5) != 0),
                       ($urandom_range(0, 5) != 0), ($urandom_range(0, 5) != 0)});
            error_VC0 = ($urandom_range(0, 299) == 0);
            error_VC1 = ($urandom_range(0, 299) == 0);
            error_D0  = ($urandom_range(0, 299) == 0);
            error_D1  = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 149) == 0) async_reset();
            else cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fsm_controller.md
FSM_CONTROLLER -- requirements
Module: fsm_controller

Interface
REQ-001 The block SHALL have parameter UMBRAL_MAX, default 4'd7, meaning the largest legal FIFO threshold.
REQ-002 The block SHALL have parameter IDLE_CYCLES, default 4, meaning the count of consecutive all-empty cycles needed for IDLE under IDLE_FILTER_EN.
REQ-003 The block SHALL have ports:
- clk  in  1  single clock, rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- init  in  1  request (re)configuration.
- Umbral_VC0, Umbral_VC1, Umbral_D0, Umbral_D1  in  4 each  requested thresholds.
- empty_fifo_VC0, empty_fifo_VC1, empty_fifo_D0, empty_fifo_D1  in  1 each  FIFO empty flags.
- error_VC0, error_VC1, error_D0, error_D1  in  1 each  FIFO error flags.
- state  out  3  current state encoding.
- idle_out, active_out, error_out  out  1 each  state indicators.
- error_src  out  4  latched error flags {D1,D0,VC1,VC0}.
- Umbral_VC0_out, Umbral_VC1_out, Umbral_D0_out, Umbral_D1_out  out  4 each  validated thresholds to the FIFOs.

Function
REQ-004 The block SHALL implement a registered FSM with states RESET=3'd0, INIT=3'd1, IDLE=3'd2, ACTIVE=3'd3, ERROR=3'd4; codes 5-7 SHALL go to RESET on the next edge.
REQ-005 All outputs SHALL be registered; an input condition SHALL appear on the outputs on the first rising edge after it is sampled (1-cycle latency).
REQ-006 Transition priority, per edge, SHALL be: any error_* high -> ERROR; else init high -> INIT; else the state-specific rule.
REQ-007 RESET SHALL go to INIT on the first edge after reset_L deasserts, regardless of init.
REQ-008 INIT SHALL capture each Umbral_* input into its Umbral_*_out on every cycle it stays in INIT, and SHALL go to IDLE when init is low.
REQ-009 Capture SHALL clamp: 0 -> 4'd1; values above UMBRAL_MAX -> UMBRAL_MAX; others unchanged.
REQ-010 Umbral_*_out SHALL hold their values in all states except INIT and RESET.
REQ-011 IDLE SHALL go to ACTIVE when any empty_fifo_* is low, and SHALL otherwise stay in IDLE.
REQ-012 ACTIVE SHALL go to IDLE when all four empty_fifo_* are high, subject to REQ-019.
REQ-013 ERROR SHALL be absorbing; only reset_L SHALL exit it, and init SHALL be ignored.
REQ-014 On entry to ERROR, error_src SHALL load the OR of the error_* inputs for that cycle; it SHALL then hold.
REQ-015 Simultaneous error and init SHALL enter ERROR; simultaneous init and not-empty in IDLE SHALL enter INIT.
REQ-016 idle_out, active_out and error_out SHALL each be high exactly when state is IDLE, ACTIVE or ERROR, respectively.

Reset
REQ-017 reset_L low SHALL, asynchronously and mid-operation, force state=RESET, all indicators to 0, error_src to 4'b0, all Umbral_*_out to 4'd1, and the idle counter to 0.

Configuration
REQ-018 Macro IDLE_FILTER_EN SHALL select the ACTIVE->IDLE filter.
REQ-019 With IDLE_FILTER_EN defined, ACTIVE SHALL go to IDLE only after IDLE_CYCLES consecutive all-empty cycles.
- The counter SHALL clear on any non-empty cycle and on leaving ACTIVE.
- The counter SHALL saturate at IDLE_CYCLES.
REQ-020 Without IDLE_FILTER_EN, the transition SHALL occur on the first all-empty cycle and no counter SHALL be built.

Structure
REQ-021 The state codes, the clamp limits 4'd1 and UMBRAL_MAX, and the error_src bit order SHALL live in a shared package/include, fsm_params.
REQ-022 One sub-module, umbral_clamp (combinational 4-bit clamp), SHALL be instantiated four times; the FSM, counter and registers SHALL stay in fsm_controller.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- Release reset_L, init=1 for 3 cycles, Umbral_D0=4'd3 -> RESET, INIT x3, then IDLE; Umbral_D0_out=4'd3.
- In INIT, Umbral_D1=4'd0 and Umbral_VC0=4'd12 -> Umbral_D1_out=4'd1, Umbral_VC0_out=4'd7.
- In IDLE, drop empty_fifo_VC1 for 1 cycle, then all empty -> ACTIVE; with the macro, IDLE after 4 empty cycles; without it, IDLE after 1 cycle.
- In ACTIVE, pulse error_D1 and init together -> ERROR, error_src=4'b1000; later init pulses keep ERROR.
- Assert reset_L low mid-ACTIVE between clock edges -> outputs zero/4'd1 immediately, state=RESET.
- In ACTIVE, raise init with all FIFOs non-empty -> INIT next cycle, thresholds re-captured.
